// File: rtl/lut_config_loader.sv
// Configuration-chain loader for one LUT tile.
// LOAD streams CHAIN_WORDS host words into the chain head. READBACK rotates the
// chain once: each tail word goes to the host and is re-injected at the head,
// so the configuration is left intact.
//
// Handshake rules: a word moves on s_valid&s_ready (host -> chain) or on
// m_valid&m_ready (chain -> host). s_ready and m_valid depend only on the
// registered state. The chain shifts (config_en=1) only on the cycle of a
// handshake. m_data is therefore stable while m_valid=1 and m_ready=0.
module lut_config_loader #(
  parameter int CONFIG_WIDTH = 8,
  parameter int CHAIN_WORDS  = 4
) (
  input  logic                    config_clk,
  input  logic                    config_rst_n,
  input  logic                    cmd_load,
  input  logic                    cmd_readback,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [CONFIG_WIDTH-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [CONFIG_WIDTH-1:0] m_data,
  output logic                    config_en,
  output logic [CONFIG_WIDTH-1:0] config_in,
  input  logic [CONFIG_WIDTH-1:0] chain_tail,
  output logic                    busy,
  output logic                    done,
  output logic                    configured,
  output logic [1:0]              dbg_state
);

  localparam int CNT_W = $clog2(CHAIN_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             configured_q, configured_d;

  // State, word counter and configured flag registers.
  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      configured_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      configured_q <= configured_d;
    end
  end

  // Next-state logic and all outputs. Outputs decode the registered state, and
  // the data paths pass through combinationally on the handshake cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    configured_d = configured_q;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    m_data       = '0;
    config_en    = 1'b0;
    config_in    = '0;
    done         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // When both commands arrive together, LOAD wins.
        if (cmd_load) begin
          state_d      = LOAD;
          cnt_d        = '0;
          configured_d = 1'b0;
        end else if (cmd_readback) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end

      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          config_en = 1'b1;
          config_in = s_data;
          if (cnt_q == LAST_IDX) begin
            state_d      = DONE;
            cnt_d        = '0;
            configured_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      READ: begin
        m_valid = 1'b1;
        m_data  = chain_tail;
        if (m_ready) begin
          // Re-inject the tail word at the head so the chain ends where it began.
          config_en = 1'b1;
          config_in = chain_tail;
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        // Commands seen in this cycle are dropped, not queued.
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign configured = configured_q;
  assign dbg_state  = state_q;

endmodule
